// File: rtl/floo_vc_router_input_buffer_pkg.sv
// Shared types for the VC router: routing enums, header/flit layout and the
// default per-VC depth that the upstream credit counter also starts from.
package floo_vc_router_input_buffer_pkg;

    typedef enum logic [1:0] {IdTable, XYRouting, SourceRouting} route_algo_e;

    typedef enum logic [2:0] {North, East, South, West, Eject} route_direction_e;

    // Flit slots per VC and initial upstream credits for one VC.
    localparam int unsigned VCDepthDefault = 3;

    typedef struct packed {
        logic             last;
        logic [3:0]       dst_id;
        route_direction_e dir;
    } floo_hdr_t;

    typedef logic [31:0] floo_payload_t;

    // Payload occupies the low bits so flit[DataLength-1:0] is the payload.
    typedef struct packed {
        floo_hdr_t     hdr;
        floo_payload_t payload;
    } floo_flit_t;

endpackage

// File: rtl/floo_vc_fifo.sv
// Single-VC FIFO. Depth need not be a power of two; pointers wrap at Depth.
// The head is read straight out of storage so it never depends on i_pop.
module floo_vc_fifo #(
    parameter int unsigned Depth  = 3,
    parameter type         flit_t = logic
) (
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_push,
    input  flit_t i_data,
    input  logic  i_pop,
    output flit_t o_head,
    output logic  o_full,
    output logic  o_empty
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    flit_t           r_mem [Depth];
    logic [PtrW-1:0] r_rd_ptr;
    logic [PtrW-1:0] r_wr_ptr;
    logic [CntW-1:0] r_count;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // Storage write; a push into a full FIFO with a same-edge pop reuses the head slot.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CntW'(Depth));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/floo_vc_router_input_buffer.sv
// Input-port VC buffer: demuxes link flits into per-VC FIFOs, exposes every
// VC head to the switch/allocators and returns one registered credit per pop.
module floo_vc_router_input_buffer
    import floo_vc_router_input_buffer_pkg::*;
#(
    parameter int unsigned NumVC          = 4,
    parameter int unsigned VCDepth        = VCDepthDefault,
    parameter type         flit_t         = floo_flit_t,
    parameter type         hdr_t          = floo_hdr_t,
    parameter type         flit_payload_t = floo_payload_t,
    parameter int unsigned DataLength     = $bits(flit_payload_t),
    parameter int unsigned VCIdxW         = (NumVC > 1) ? $clog2(NumVC) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                valid_i,
    input  logic [VCIdxW-1:0]                   vc_id_i,
    input  flit_t                               data_i,
    output logic                                credit_valid_o,
    output logic [VCIdxW-1:0]                   credit_id_o,
    output logic [NumVC-1:0][DataLength-1:0]    vc_data_head_o,
    output hdr_t [NumVC-1:0]                    vc_ctrl_head_o,
    output logic [NumVC-1:0]                    vc_valid_o,
    input  logic                                read_valid_i,
    input  logic [NumVC-1:0]                    read_vc_id_oh_i
);

    logic [NumVC-1:0]  w_push;
    logic [NumVC-1:0]  w_pop;
    logic [NumVC-1:0]  w_full;
    logic [NumVC-1:0]  w_empty;
    logic [VCIdxW-1:0] w_pop_idx;
    flit_t             w_head [NumVC];
    logic              r_credit_valid;
    logic [VCIdxW-1:0] r_credit_id;

    // Encode the one-hot pop select into the VC index carried by the credit.
    always_comb begin
        w_pop_idx = '0;
        for (int unsigned v = 0; v < NumVC; v++) begin
            if (read_vc_id_oh_i[v]) begin
                w_pop_idx = w_pop_idx | VCIdxW'(v);
            end
        end
    end

    for (genvar v = 0; v < NumVC; v++) begin : gen_vc
        assign w_push[v] = valid_i && (vc_id_i == VCIdxW'(v));
        assign w_pop[v]  = read_valid_i && read_vc_id_oh_i[v];

        floo_vc_fifo #(
            .Depth  (VCDepth),
            .flit_t (flit_t)
        ) u_fifo (
            .i_clk   (clk_i),
            .i_rst   (rst_i),
            .i_push  (w_push[v]),
            .i_data  (data_i),
            .i_pop   (w_pop[v]),
            .o_head  (w_head[v]),
            .o_full  (w_full[v]),
            .o_empty (w_empty[v])
        );

        assign vc_valid_o[v]     = !w_empty[v];
        assign vc_data_head_o[v] = w_head[v][DataLength-1:0];
        assign vc_ctrl_head_o[v] = w_head[v].hdr;

        a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
            !(w_push[v] && w_full[v] && !w_pop[v]));
        a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
            !(w_pop[v] && w_empty[v]));
    end

    a_pop_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
        read_valid_i |-> $onehot(read_vc_id_oh_i));
    a_vc_id_range : assert property (@(posedge clk_i) disable iff (rst_i)
        valid_i |-> (int'(vc_id_i) < int'(NumVC)));

    // Credit return register: one credit, one cycle after each pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_credit_valid <= 1'b0;
            r_credit_id    <= '0;
        end else begin
            r_credit_valid <= read_valid_i;
            r_credit_id    <= read_valid_i ? w_pop_idx : '0;
        end
    end

    assign credit_valid_o = r_credit_valid;
    assign credit_id_o    = r_credit_id;

endmodule

// File: tb/tb_floo_vc_router_input_buffer.sv
// Bench for the VC input buffer: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against per-VC queues.
module tb_floo_vc_router_input_buffer;
    import floo_vc_router_input_buffer_pkg::*;

    localparam int unsigned NumVC   = 4;
    localparam int unsigned VCDepth = 3;
    localparam int unsigned VCIdxW  = 2;
    localparam int unsigned DataLen = 32;

    logic                            clk = 1'b0;
    logic                            rst = 1'b1;
    logic                            valid_i = 1'b0;
    logic [VCIdxW-1:0]               vc_id_i = '0;
    floo_flit_t                      data_i = '0;
    logic                            credit_valid_o;
    logic [VCIdxW-1:0]               credit_id_o;
    logic [NumVC-1:0][DataLen-1:0]   vc_data_head_o;
    floo_hdr_t [NumVC-1:0]           vc_ctrl_head_o;
    logic [NumVC-1:0]                vc_valid_o;
    logic                            read_valid_i = 1'b0;
    logic [NumVC-1:0]                read_vc_id_oh_i = '0;

    floo_vc_router_input_buffer #(
        .NumVC   (NumVC),
        .VCDepth (VCDepth)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .valid_i         (valid_i),
        .vc_id_i         (vc_id_i),
        .data_i          (data_i),
        .credit_valid_o  (credit_valid_o),
        .credit_id_o     (credit_id_o),
        .vc_data_head_o  (vc_data_head_o),
        .vc_ctrl_head_o  (vc_ctrl_head_o),
        .vc_valid_o      (vc_valid_o),
        .read_valid_i    (read_valid_i),
        .read_vc_id_oh_i (read_vc_id_oh_i)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_credits = 0;

    // Reference state: contents of every VC in arrival order, plus the expected credit.
    floo_flit_t        q [NumVC][$];
    logic              exp_cv = 1'b0;
    logic [VCIdxW-1:0] exp_cid = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic floo_flit_t mk(input logic [7:0] h, input logic [31:0] p);
        floo_flit_t f;
        f = {h, p};
        return f;
    endfunction

    // Model update at each edge: pop first so a full VC can accept a same-edge write.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int v = 0; v < NumVC; v++) q[v].delete();
                exp_cv  = 1'b0;
                exp_cid = '0;
            end else begin
                exp_cv  = read_valid_i;
                exp_cid = '0;
                if (read_valid_i) begin
                    for (int v = 0; v < NumVC; v++) begin
                        if (read_vc_id_oh_i[v] && q[v].size() != 0) begin
                            exp_cid = VCIdxW'(v);
                            void'(q[v].pop_front());
                        end
                    end
                end
                if (valid_i) q[vc_id_i].push_back(data_i);
            end
        end
    end

    // Per-cycle comparison of every output against the model, away from the active edge.
    always @(negedge clk) begin
        logic [NumVC-1:0] ev;
        floo_flit_t       h;
        if (!rst) begin
            ev = '0;
            for (int v = 0; v < NumVC; v++) ev[v] = (q[v].size() != 0);
            check("vc_valid", 64'(vc_valid_o), 64'(ev));
            for (int v = 0; v < NumVC; v++) begin
                if (q[v].size() != 0) begin
                    h = q[v][0];
                    check("head_data", 64'(vc_data_head_o[v]), 64'(h.payload));
                    check("head_hdr", 64'(vc_ctrl_head_o[v]), 64'(h.hdr));
                end
            end
            check("credit_valid", 64'(credit_valid_o), 64'(exp_cv));
            if (exp_cv) check("credit_id", 64'(credit_id_o), 64'(exp_cid));
            if (credit_valid_o) n_credits++;
        end
    end

    task automatic step(input logic wv, input int wvc, input floo_flit_t wd,
                        input logic rv, input int rvc);
        valid_i         = wv;
        vc_id_i         = VCIdxW'(wvc);
        data_i          = wd;
        read_valid_i    = rv;
        read_vc_id_oh_i = rv ? (NumVC'(1) << rvc) : '0;
        @(posedge clk);
        @(negedge clk);
        valid_i      = 1'b0;
        read_valid_i = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 0, '0, 1'b0, 0);
    endtask

    initial begin
        int         base;
        logic       rv;
        logic       wv;
        int         rvc;
        int         wvc;
        int         start;
        int         c;
        floo_flit_t f;
        logic [39:0] bits;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_vc_valid", 64'(vc_valid_o), 64'h0);
        check("rst_credit_valid", 64'(credit_valid_o), 64'h0);
        check("rst_credit_id", 64'(credit_id_o), 64'h0);

        // Single flit through VC2.
        step(1'b1, 2, mk(8'h12, 32'hA0A0_0002), 1'b0, 0);
        check("single_valid", 64'(vc_valid_o), 64'h4);
        check("single_data", 64'(vc_data_head_o[2]), 64'hA0A0_0002);
        check("single_hdr", 64'(vc_ctrl_head_o[2]), 64'h12);
        idle();
        idle();
        step(1'b0, 0, '0, 1'b1, 2);
        check("single_empty", 64'(vc_valid_o), 64'h0);
        check("single_credit", 64'(credit_valid_o), 64'h1);
        check("single_credit_id", 64'(credit_id_o), 64'h2);
        idle();
        check("single_credit_once", 64'(credit_valid_o), 64'h0);

        // Fill VC0 then drain in order.
        step(1'b1, 0, mk(8'h01, 32'hA), 1'b0, 0);
        step(1'b1, 0, mk(8'h02, 32'hB), 1'b0, 0);
        step(1'b1, 0, mk(8'h03, 32'hC), 1'b0, 0);
        check("fill_head_a", 64'(vc_data_head_o[0]), 64'hA);
        step(1'b0, 0, '0, 1'b1, 0);
        check("fill_head_b", 64'(vc_data_head_o[0]), 64'hB);
        check("fill_credit_id", 64'(credit_id_o), 64'h0);
        step(1'b0, 0, '0, 1'b1, 0);
        check("fill_head_c", 64'(vc_data_head_o[0]), 64'hC);
        step(1'b0, 0, '0, 1'b1, 0);
        check("fill_empty", 64'(vc_valid_o), 64'h0);

        // Full VC3 with a same-cycle write and pop.
        step(1'b1, 3, mk(8'h31, 32'h5858), 1'b0, 0);
        step(1'b1, 3, mk(8'h32, 32'h5959), 1'b0, 0);
        step(1'b1, 3, mk(8'h33, 32'h5A5A), 1'b0, 0);
        step(1'b1, 3, mk(8'h34, 32'h5757), 1'b1, 3);
        check("full_head_y", 64'(vc_data_head_o[3]), 64'h5959);
        check("full_credit_id", 64'(credit_id_o), 64'h3);
        step(1'b0, 0, '0, 1'b1, 3);
        check("full_head_z", 64'(vc_data_head_o[3]), 64'h5A5A);
        step(1'b0, 0, '0, 1'b1, 3);
        check("full_head_w", 64'(vc_data_head_o[3]), 64'h5757);
        check("full_hdr_w", 64'(vc_ctrl_head_o[3]), 64'h34);
        step(1'b0, 0, '0, 1'b1, 3);

        // VC isolation: popping VC1 leaves VC0 untouched.
        step(1'b1, 0, mk(8'h40, 32'hF0), 1'b0, 0);
        step(1'b1, 1, mk(8'h41, 32'hE0), 1'b0, 0);
        step(1'b1, 0, mk(8'h42, 32'hF1), 1'b0, 0);
        step(1'b1, 1, mk(8'h43, 32'hE1), 1'b0, 0);
        step(1'b0, 0, '0, 1'b1, 1);
        check("iso_vc0_head", 64'(vc_data_head_o[0]), 64'hF0);
        check("iso_credit_id", 64'(credit_id_o), 64'h1);
        step(1'b0, 0, '0, 1'b1, 1);
        check("iso_vc0_head2", 64'(vc_data_head_o[0]), 64'hF0);
        check("iso_valid", 64'(vc_valid_o), 64'h1);
        step(1'b0, 0, '0, 1'b1, 0);
        step(1'b0, 0, '0, 1'b1, 0);

        // Pointer wrap on VC1: ten write/pop pairs.
        idle();
        base = n_credits;
        step(1'b1, 1, mk(8'h50, 32'hC000_0000), 1'b0, 0);
        for (int i = 1; i < 10; i++) begin
            step(1'b1, 1, mk(8'h50 + 8'(i), 32'hC000_0000 + 32'(i)), 1'b1, 1);
            check("wrap_head", 64'(vc_data_head_o[1]), 64'(32'hC000_0000 + 32'(i)));
        end
        step(1'b0, 0, '0, 1'b1, 1);
        idle();
        check("wrap_credits", 64'(n_credits - base), 64'd10);

        // Asynchronous reset while VC1 holds a flit and a credit is pending.
        step(1'b1, 1, mk(8'h60, 32'hD0), 1'b0, 0);
        step(1'b1, 1, mk(8'h61, 32'hD1), 1'b0, 0);
        step(1'b0, 0, '0, 1'b1, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_vc_valid", 64'(vc_valid_o), 64'h0);
        check("arst_credit", 64'(credit_valid_o), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        base = n_credits;
        repeat (3) idle();
        check("arst_no_credit", 64'(n_credits - base), 64'd0);
        check("arst_still_empty", 64'(vc_valid_o), 64'h0);

        // Randomized legal traffic.
        for (int i = 0; i < 3000; i++) begin
            rv  = 1'b0;
            rvc = 0;
            if ($urandom_range(3) != 0) begin
                start = $urandom_range(NumVC - 1);
                for (int k = 0; k < NumVC; k++) begin
                    c = (start + k) % NumVC;
                    if (!rv && q[c].size() != 0) begin
                        rv  = 1'b1;
                        rvc = c;
                    end
                end
            end
            wvc  = $urandom_range(NumVC - 1);
            wv   = ($urandom_range(3) != 0) &&
                   ((q[wvc].size() < VCDepth) || (rv && rvc == wvc));
            bits = {8'($urandom), 32'($urandom)};
            f    = bits;
            step(wv, wvc, f, rv, rvc);
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
